// File: rtl/sd_spi_host_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : sd_spi_host_cmd
//  Purpose  : SPI-mode SD host command engine. Optionally sends the power-up
//             clock train with CS_n high, then one 6-byte command frame, polls
//             for R1 and captures up to four trailing response bytes.
//  Revision : 1.0  initial release
// ============================================================================
module sd_spi_host_cmd #(
  parameter int CLK_DIV    = 6,
  parameter int NCR_MAX    = 8,
  parameter int INIT_BYTES = 10
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        cmd_start,
  input  logic        init_clocks,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic [2:0]  resp_extra_bytes,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_data,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  input  logic        spi_miso
);

  localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]       INIT_LAST = 8'(INIT_BYTES - 1);
  localparam logic [7:0]       NCR_LAST  = 8'(NCR_MAX - 1);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SETUP   = 4'd1,
    ST_INIT    = 4'd2,
    ST_PRE     = 4'd3,
    ST_CMD     = 4'd4,
    ST_WAIT_R1 = 4'd5,
    ST_EXTRA   = 4'd6,
    ST_POST    = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic             run_q, run_d;          // a byte is being shifted
  logic [DIV_W-1:0] div_q, div_d;          // position inside an SCLK half-period
  logic [2:0]       bit_q, bit_d;          // bit index inside the current byte
  logic [7:0]       tx_q, tx_d;            // outgoing shift register
  logic [7:0]       rx_q, rx_d;            // incoming shift register
  logic [7:0]       cnt_q, cnt_d;          // byte counter inside the current phase
  logic [5:0]       idx_q, idx_d;
  logic [31:0]      arg_q, arg_d;
  logic [6:0]       crc_q, crc_d;
  logic [2:0]       extra_q, extra_d;
  logic             init_q, init_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       r1_q, r1_d;
  logic [31:0]      data_q, data_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;

  logic             byte_end;
  logic             load;
  logic [7:0]       load_byte;

  // Next-state logic: command sequencing plus the mode-0 bit engine.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    arg_d     = arg_q;
    crc_d     = crc_q;
    extra_d   = extra_q;
    init_d    = init_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    r1_d      = r1_q;
    data_d    = data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    byte_end  = 1'b0;
    load      = 1'b0;
    load_byte = 8'hFF;

    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          idx_d     = cmd_index;
          arg_d     = cmd_arg;
          crc_d     = cmd_crc;
          extra_d   = (resp_extra_bytes > 3'd4) ? 3'd4 : resp_extra_bytes;
          init_d    = init_clocks;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          data_d    = 32'd0;
          state_d   = ST_SETUP;
        end
      end
      // One cycle of chip-select setup before the first SCLK activity.
      ST_SETUP: begin
        cs_n_d  = init_q;
        cnt_d   = 8'd0;
        state_d = init_q ? ST_INIT : ST_PRE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        if (!run_q) begin
          load = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (!sclk_q) begin
              sclk_d = 1'b1;
              rx_d   = {rx_q[6:0], spi_miso};
            end else begin
              sclk_d = 1'b0;
              if (bit_q != 3'd7) begin
                bit_d  = bit_q + 3'd1;
                tx_d   = {tx_q[6:0], 1'b1};
                mosi_d = tx_q[6];
              end else begin
                byte_end = 1'b1;
              end
            end
          end
        end
      end
    endcase

    // Phase decisions at the falling edge that closes a byte.
    if (byte_end) begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == INIT_LAST) begin
            cnt_d   = 8'd0;
            cs_n_d  = 1'b0;
            state_d = ST_PRE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_PRE: begin
          cnt_d   = 8'd0;
          state_d = ST_CMD;
        end
        ST_CMD: begin
          if (cnt_q == 8'd5) begin
            cnt_d   = 8'd0;
            state_d = ST_WAIT_R1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_WAIT_R1: begin
          if (!rx_q[7]) begin
            r1_d    = rx_q;
            cnt_d   = 8'd0;
            state_d = (extra_q == 3'd0) ? ST_POST : ST_EXTRA;
          end else if (cnt_q == NCR_LAST) begin
            r1_d      = 8'hFF;
            timeout_d = 1'b1;
            state_d   = ST_POST;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_EXTRA: begin
          data_d = {data_q[23:0], rx_q};
          if (cnt_q == {5'd0, extra_q} - 8'd1) begin
            state_d = ST_POST;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_POST: begin
          run_d   = 1'b0;
          done_d  = 1'b1;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b1;
          state_d = ST_DONE;
        end
        default: ;
      endcase
    end

    // Only the command frame carries data; every other byte is 0xFF.
    if (state_d == ST_CMD) begin
      case (cnt_d)
        8'd0:    load_byte = {2'b01, idx_q};
        8'd1:    load_byte = arg_q[31:24];
        8'd2:    load_byte = arg_q[23:16];
        8'd3:    load_byte = arg_q[15:8];
        8'd4:    load_byte = arg_q[7:0];
        8'd5:    load_byte = {crc_q, 1'b1};
        default: load_byte = 8'hFF;
      endcase
    end

    // Back-to-back byte loading: first bit goes out while SCLK is low.
    if (load || (byte_end && (state_d != ST_DONE))) begin
      run_d  = 1'b1;
      div_d  = '0;
      bit_d  = 3'd0;
      sclk_d = 1'b0;
      tx_d   = load_byte;
      mosi_d = load_byte[7];
    end
  end

  // State and registered-output flops with asynchronous clear.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      div_q     <= '0;
      bit_q     <= 3'd0;
      tx_q      <= 8'hFF;
      rx_q      <= 8'hFF;
      cnt_q     <= 8'd0;
      idx_q     <= 6'd0;
      arg_q     <= 32'd0;
      crc_q     <= 7'd0;
      extra_q   <= 3'd0;
      init_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      r1_q      <= 8'hFF;
      data_q    <= 32'd0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      arg_q     <= arg_d;
      crc_q     <= crc_d;
      extra_q   <= extra_d;
      init_q    <= init_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      r1_q      <= r1_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign resp_r1   = r1_q;
  assign resp_data = data_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs_n  = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_host_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_spi_host_cmd
//  Purpose  : Self-checking bench for sd_spi_host_cmd with a byte-level SD card
//             model and a transaction-level reference for frame and response.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sd_spi_host_cmd;

  localparam int CLK_DIV    = 2;
  localparam int NCR_MAX    = 8;
  localparam int INIT_BYTES = 10;
  localparam int BYTE_CYC   = 16 * CLK_DIV;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic        init_clocks = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic [6:0]  cmd_crc = 7'd0;
  logic [2:0]  resp_extra_bytes = 3'd0;
  logic        busy, done, timeout;
  logic [7:0]  resp_r1;
  logic [31:0] resp_data;
  logic        spi_sclk, spi_mosi, spi_cs_n;
  logic        spi_miso = 1'b1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Card script: bytes the card returns starting at the first poll byte.
  logic [7:0] script [16];
  int         script_len = 0;
  logic [7:0] cap [$];
  int         init_rises = 0;
  int         init_zero = 0;

  // Expected busy/done window of the current command.
  logic m_active = 1'b0;
  int   m_ca = 0;
  int   m_x = 0;
  int   lat_meas = 0;

  sd_spi_host_cmd #(
    .CLK_DIV   (CLK_DIV),
    .NCR_MAX   (NCR_MAX),
    .INIT_BYTES(INIT_BYTES)
  ) dut (
    .clk_50          (clk_50),
    .reset_n         (reset_n),
    .cmd_start       (cmd_start),
    .init_clocks     (init_clocks),
    .cmd_index       (cmd_index),
    .cmd_arg         (cmd_arg),
    .cmd_crc         (cmd_crc),
    .resp_extra_bytes(resp_extra_bytes),
    .busy            (busy),
    .done            (done),
    .timeout         (timeout),
    .resp_r1         (resp_r1),
    .resp_data       (resp_data),
    .spi_sclk        (spi_sclk),
    .spi_mosi        (spi_mosi),
    .spi_cs_n        (spi_cs_n),
    .spi_miso        (spi_miso)
  );

  // 50 MHz-style clock.
  always #5 clk_50 = ~clk_50;

  // Free-running cycle counter used for latency and window checks.
  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] card_byte(input int n);
    if (n < 7 || (n - 7) >= script_len) return 8'hFF;
    return script[n - 7];
  endfunction

  // SD card model: counts SCLK rises, collects MOSI bytes, shifts MISO.
  initial begin : card
    logic       sclk_prev;
    int         cbit;
    int         cbyte;
    logic [7:0] sh;
    logic [7:0] cur;
    sclk_prev = 1'b0;
    cbit = 0;
    cbyte = 0;
    sh = 8'h00;
    forever begin
      @(negedge clk_50);
      if (!reset_n || spi_cs_n) begin
        if (reset_n && spi_sclk && !sclk_prev) begin
          init_rises++;
          if (!spi_mosi) init_zero++;
        end
        cbit = 0;
        cbyte = 0;
        spi_miso = 1'b1;
      end else begin
        if (spi_sclk && !sclk_prev) begin
          sh = {sh[6:0], spi_mosi};
          cbit++;
          if (cbit == 8) begin
            cap.push_back(sh);
            cbit = 0;
            cbyte++;
          end
        end
        cur = card_byte(cbyte);
        spi_miso = cur[7 - cbit];
      end
      sclk_prev = spi_sclk;
    end
  end

  // Per-cycle compare: busy/done window, idle pin levels, CS edge safety.
  initial begin : compare
    logic cs_prev;
    logic eb;
    logic ed;
    cs_prev = 1'b1;
    forever begin
      @(negedge clk_50);
      if (reset_n) begin
        eb = m_active && (cyc >= m_ca) && (cyc <= m_ca + m_x);
        ed = m_active && (cyc == m_ca + m_x);
        check("busy_done", {busy, done}, {eb, ed});
        if (!eb) check("idle_pins", {spi_sclk, spi_cs_n, spi_mosi}, 3'b011);
        if (spi_cs_n !== cs_prev) check("cs_edge_sclk", spi_sclk, 1'b0);
      end
      cs_prev = spi_cs_n;
    end
  end

  // Runs one command against the card script and checks it end to end.
  task automatic run_cmd(input bit init, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [6:0] crc, input logic [2:0] extra, input bit poke);
    int         k;
    bit         to;
    int         e;
    int         x;
    bit         seen;
    logic [7:0] er1;
    logic [31:0] ed;
    logic [7:0] ef [$];

    to = 1'b1;
    k = NCR_MAX;
    for (int i = 0; i < NCR_MAX; i++)
      if (to && i < script_len && !script[i][7]) begin
        to = 1'b0;
        k = i + 1;
      end
    e   = to ? 0 : ((extra > 3'd4) ? 4 : int'(extra));
    er1 = to ? 8'hFF : script[k - 1];
    ed  = 32'd0;
    for (int i = 0; i < e; i++) ed = {ed[23:0], card_byte(7 + k + i)};
    ef.push_back(8'hFF);
    ef.push_back({2'b01, idx});
    ef.push_back(arg[31:24]);
    ef.push_back(arg[23:16]);
    ef.push_back(arg[15:8]);
    ef.push_back(arg[7:0]);
    ef.push_back({crc, 1'b1});
    for (int i = 0; i < k + e + 1; i++) ef.push_back(8'hFF);
    x = ((init ? INIT_BYTES : 0) + 8 + k + e) * BYTE_CYC + 2;

    cap.delete();
    init_rises = 0;
    init_zero = 0;
    @(negedge clk_50);
    init_clocks = init;
    cmd_index = idx;
    cmd_arg = arg;
    cmd_crc = crc;
    resp_extra_bytes = extra;
    cmd_start = 1'b1;
    @(posedge clk_50);
    #1;
    cmd_start = 1'b0;
    m_ca = cyc;
    m_x = x;
    m_active = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < x + 200 && !seen; i++) begin
      @(negedge clk_50);
      if (done) begin
        seen = 1'b1;
      end else if (poke && cyc == m_ca + 100) begin
        cmd_start = 1'b1;
        cmd_index = ~idx;
        cmd_arg = ~arg;
        cmd_crc = ~crc;
        init_clocks = 1'b1;
      end else begin
        cmd_start = 1'b0;
      end
    end
    lat_meas = cyc - m_ca;
    check("done_seen", seen, 1'b1);
    if (poke) begin
      cmd_start = 1'b1;
      @(posedge clk_50);
      #1;
      cmd_start = 1'b0;
    end
    @(negedge clk_50);
    check("cs_released", spi_cs_n, 1'b1);
    check("latency", lat_meas, x);
    check("resp_r1", resp_r1, er1);
    check("timeout", timeout, to);
    check("resp_data", resp_data, ed);
    check("frame_len", cap.size(), ef.size());
    if (cap.size() == ef.size())
      for (int i = 0; i < ef.size(); i++) check("frame_byte", {i[7:0], cap[i]}, {i[7:0], ef[i]});
    check("init_rises", init_rises, init ? 8 * INIT_BYTES : 0);
    check("init_mosi_high", init_zero, 0);
  endtask

  initial begin : main
    logic [7:0] lit0 [11];
    bit         got;
    lit0 = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Reset state.
    repeat (3) @(posedge clk_50);
    #1;
    check("reset_state", {busy, done, timeout, resp_r1, resp_data, spi_sclk, spi_mosi, spi_cs_n},
          {1'b0, 1'b0, 1'b0, 8'hFF, 32'd0, 1'b0, 1'b1, 1'b1});
    @(posedge clk_50);
    #2;
    reset_n = 1'b1;
    repeat (3) @(posedge clk_50);

    // CMD0 with init train; card answers FF,FF,01.
    script[0] = 8'hFF; script[1] = 8'hFF; script[2] = 8'h01; script_len = 3;
    run_cmd(1'b1, 6'd0, 32'd0, 7'h4A, 3'd0, 1'b0);
    check("cmd0_frame_len", cap.size(), 11);
    if (cap.size() == 11)
      for (int i = 0; i < 11; i++) check("cmd0_byte", cap[i], lit0[i]);
    check("cmd0_r1", resp_r1, 8'h01);
    check("cmd0_init_rises", init_rises, 80);

    // CMD8 with R7 trailer.
    script[0] = 8'h01; script[1] = 8'h00; script[2] = 8'h00; script[3] = 8'h01; script[4] = 8'hAA;
    script_len = 5;
    run_cmd(1'b0, 6'd8, 32'h0000_01AA, 7'h43, 3'd4, 1'b0);
    check("cmd8_data", resp_data, 32'h0000_01AA);
    check("cmd8_latency", lat_meas, 418);
    if (cap.size() > 6) check("cmd8_first_last", {cap[1], cap[6]}, 16'h4887);

    // MISO stuck high: timeout after NCR_MAX polls.
    script_len = 0;
    run_cmd(1'b0, 6'd17, 32'hDEAD_BEEF, 7'h11, 3'd4, 1'b0);
    check("to_flags", {timeout, resp_r1, resp_data}, {1'b1, 8'hFF, 32'd0});
    check("to_bytes", cap.size(), 16);

    // Two trailing bytes.
    script[0] = 8'h00; script[1] = 8'h12; script[2] = 8'h34; script_len = 3;
    run_cmd(1'b0, 6'd55, 32'h0, 7'h32, 3'd2, 1'b0);
    check("extra2_data", resp_data, 32'h0000_1234);

    // Extra count 7 is limited to four bytes.
    script[0] = 8'h01; script[1] = 8'hA1; script[2] = 8'hB2; script[3] = 8'hC3;
    script[4] = 8'hD4; script[5] = 8'hE5; script[6] = 8'hF6; script_len = 7;
    run_cmd(1'b0, 6'd58, 32'h0, 7'h7E, 3'd7, 1'b0);
    check("extra7_data", resp_data, 32'hA1B2_C3D4);

    // Start pulses during CMD and coincident with done are ignored.
    script[0] = 8'hFF; script[1] = 8'h05; script[2] = 8'h9C; script[3] = 8'h3E;
    script[4] = 8'h11; script_len = 5;
    run_cmd(1'b0, 6'd41, 32'h4030_0000, 7'h3B, 3'd3, 1'b1);
    repeat (4) @(negedge clk_50);
    check("no_restart", busy, 1'b0);

    // Asynchronous reset in the middle of CMD byte 3.
    script[0] = 8'h01; script_len = 1;
    @(negedge clk_50);
    init_clocks = 1'b0; cmd_index = 6'd17; cmd_arg = 32'h1234_5678; cmd_crc = 7'h2A;
    resp_extra_bytes = 3'd0; cmd_start = 1'b1;
    cap.delete();
    @(posedge clk_50);
    #1;
    cmd_start = 1'b0;
    m_ca = cyc; m_x = 1 << 20; m_active = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 * BYTE_CYC && !got; i++) begin
      @(negedge clk_50);
      if (cap.size() >= 4) got = 1'b1;
    end
    check("reset_reach_cmd3", got, 1'b1);
    repeat (5) @(posedge clk_50);
    #2;
    m_active = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_reset_pins", {spi_sclk, spi_cs_n, spi_mosi, busy, done}, 5'b01100);
    check("async_reset_resp", {timeout, resp_r1, resp_data}, {1'b0, 8'hFF, 32'd0});
    repeat (3) @(posedge clk_50);
    #2;
    reset_n = 1'b1;
    script[0] = 8'hFF; script[1] = 8'h00; script[2] = 8'h77; script_len = 3;
    run_cmd(1'b0, 6'd24, 32'h0000_0200, 7'h55, 3'd1, 1'b0);

    // Randomized commands and card responses.
    for (int t = 0; t < 25; t++) begin
      int lead;
      lead = $urandom_range(0, NCR_MAX + 1);
      script_len = 0;
      for (int i = 0; i < lead; i++) begin
        script[script_len] = 8'($urandom) | 8'h80;
        script_len++;
      end
      script[script_len] = 8'($urandom) & 8'h7F;
      script_len++;
      for (int i = 0; i < 4; i++) begin
        script[script_len] = 8'($urandom);
        script_len++;
      end
      run_cmd($urandom_range(0, 3) == 0, 6'($urandom), $urandom, 7'($urandom), 3'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_spi_host_cmd.md
Name: sd_spi_host_cmd

Overview:
SPI-mode SD host command engine. It is the initiator counterpart of the card emulator's SPI path: it drives SCLK, CS_n and MOSI, and samples MISO. It can optionally send the power-up clock train with CS deasserted, then sends one 6-byte command frame, polls for the R1 response, and captures up to 4 trailing response bytes (R3/R7). It sits between host-side test/bring-up logic and the card pins, in the clk_50 domain.

Parameters:
CLK_DIV, 6, clk_50 cycles per SCLK half-period (>=1); one SPI bit takes 2*CLK_DIV cycles.
NCR_MAX, 8, maximum number of 0xFF poll bytes sent while waiting for R1 before timing out (1..255).
INIT_BYTES, 10, number of 0xFF bytes sent with CS_n high in the init phase (10 bytes = 80 clocks).

Ports:
clk_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_start  in  1  single-cycle start pulse; ignored while busy=1
init_clocks  in  1  sampled with cmd_start; 1 = run the init phase first
cmd_index  in  6  command index; sent as byte 0x40|cmd_index
cmd_arg  in  32  argument, sent MSB byte first
cmd_crc  in  7  CRC7; last frame byte is {cmd_crc,1'b1}
resp_extra_bytes  in  3  bytes to read after R1 (0=R1, 4=R3/R7); values 5..7 are treated as 4
busy  out  1  high from the cycle after an accepted cmd_start until done
done  out  1  one-cycle completion pulse
timeout  out  1  valid with done; 1 = no R1 within NCR_MAX bytes
resp_r1  out  8  captured R1; 0xFF on timeout
resp_data  out  32  trailing bytes, right-aligned, first byte most significant
spi_sclk  out  1  SPI clock, mode 0, idles low
spi_mosi  out  1  host data out, idles high
spi_cs_n  out  1  chip select, active low
spi_miso  in  1  card data out, already synchronized

Behaviour:
- Reset values (async, immediate, also mid-operation): spi_sclk=0, spi_mosi=1, spi_cs_n=1, busy=0, done=0, timeout=0, resp_r1=8'hFF, resp_data=0. All counters and state are cleared; the next command starts clean.
- Byte engine (mode 0, MSB first):
  - MOSI updates while SCLK is low, at byte start and on each falling edge.
  - SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles, per bit.
  - MISO is sampled in the clk_50 cycle in which SCLK rises.
  - One byte takes 16*CLK_DIV cycles. Bytes are back-to-back with no gap.
- FSM:
  - IDLE: on cmd_start with busy=0, latch all inputs and set busy=1. Go to INIT if init_clocks=1, else PRE.
  - INIT: send INIT_BYTES bytes of 0xFF with cs_n=1, then go to PRE.
  - PRE: cs_n=0; send one 0xFF byte.
  - CMD: send 0x40|idx, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc,1}.
  - WAIT_R1: send 0xFF bytes. The first received byte with bit7=0 is latched into resp_r1; go to EXTRA, or to POST if the extra count is 0. After NCR_MAX bytes with bit7=1: resp_r1=0xFF, set the timeout flag, skip EXTRA, go to POST.
  - EXTRA: send 0xFF; for each received byte, resp_data <= {resp_data[23:0], byte}. resp_data is cleared to 0 at command acceptance.
  - POST: send one 0xFF byte with cs_n=0.
  - DONE (1 cycle): cs_n=1, done=1, busy=0, timeout valid. Then IDLE.
- Latency with no init, R1 on poll byte k (1-based) and E extra bytes: done fires (8+k+E)*16*CLK_DIV + 2 cycles after cmd_start.
- timeout and resp_* hold their values until the next accepted cmd_start. timeout clears at acceptance.
- If cmd_start and done coincide, cmd_start is ignored, because busy is still 1 in that cycle.
- cs_n never toggles in mid-byte; SCLK is never high when cs_n changes.

Test Plan:
- CLK_DIV=2, init_clocks=1, CMD0 (idx 0, arg 0, crc 0x4A); model returns FF,FF,01 -> 80 SCLK rises with cs_n=1, then MOSI bytes FF,40,00,00,00,00,95,FF,FF,FF,FF; resp_r1=0x01, timeout=0, done pulses once, cs_n returns to 1.
- CMD8 (idx 8, arg 0x000001AA, crc 0x43, extra=4); model returns 01,00,00,01,AA -> frame 48 00 00 01 AA 87; resp_r1=0x01, resp_data=0x000001AA.
- MISO stuck at 1, NCR_MAX=8 -> exactly 8 poll bytes, then the POST byte; timeout=1, resp_r1=0xFF, resp_data=0.
- Extra=2 with trailing bytes 12,34 -> resp_data=0x00001234. Extra=7 reads exactly 4 bytes.
- cmd_start pulsed during CMD, and again coincident with done -> both ignored; the frame is unaltered; only one done pulse.
- reset_n low mid-CMD byte 3 -> cs_n=1, sclk=0, mosi=1, busy=0 the same instant. The next command after release produces a correct full frame.
